dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: accepts one core request at a time, inserts
// WAIT_CYCLES wait states, then strobes dmem_ready with read data / error status.

module dmem_lane #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    // Contents are deliberately not reset.
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk)
        if (we) mem[idx] <= wdata;

    assign rdata = mem[idx];
endmodule

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_req,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_we,
    input  logic [3:0]  dmem_be,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        dmem_err,
    output logic        busy
);
    localparam int NUM_LANES = 4;
    localparam int AW        = $clog2(DEPTH_WORDS);

    typedef struct packed {
        logic [29:0]                word;
        logic                       we;
        logic [NUM_LANES-1:0]       be;
        logic [NUM_LANES-1:0][7:0]  wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                    state, state_nxt;
    logic [3:0]                cnt, cnt_nxt;
    req_t                      req_q, req_cur;
    logic                      err_q;
    logic                      oor, start_resp;
    logic [AW-1:0]             idx;
    logic [NUM_LANES-1:0]      lane_we;
    logic [NUM_LANES-1:0][7:0] lane_rdata;
    logic                      unused_addr_lsb;

    assign unused_addr_lsb = ^dmem_addr[1:0];

    // With WAIT_CYCLES=0 the access happens on the accepting edge, so the
    // live inputs must feed the array directly while still in IDLE.
    assign req_cur    = (state == IDLE) ? {dmem_addr[31:2], dmem_we, dmem_be, dmem_wdata} : req_q;
    assign idx        = req_cur.word[AW-1:0];
    assign oor        = (req_cur.word >= 30'(DEPTH_WORDS));
    assign start_resp = (state_nxt == RESP);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (dmem_req) begin
                cnt_nxt   = 4'(WAIT_CYCLES);
                state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        // rst_n gating keeps a request presented during reset from writing.
        assign lane_we[g] = rst_n && start_resp && req_cur.we && req_cur.be[g] && !oor;

        dmem_lane #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_lane (
            .clk   (clk),
            .we    (lane_we[g]),
            .idx   (idx),
            .wdata (req_cur.wdata[g]),
            .rdata (lane_rdata[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            req_q      <= '0;
            err_q      <= 1'b0;
            dmem_rdata <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && dmem_req) req_q <= req_cur;
            if (start_resp) begin
                err_q <= oor;
                if (!req_cur.we) dmem_rdata <= oor ? '0 : lane_rdata;
            end
        end
    end

    assign dmem_ready = (state == RESP);
    assign dmem_err   = (state == RESP) && err_q;
    assign busy       = (state != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (WAIT_CYCLES 1, 0, 15)
// share clock/reset; a monitor pops expected responses on every dmem_ready.

module tb_dmem_responder;
    localparam int N = 3;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic [N-1:0]       req, we;
    logic [N-1:0][31:0] addr, wdata;
    logic [N-1:0][3:0]  be;
    wire  [N-1:0]       ready, err, busy;
    wire  [N-1:0][31:0] rdata;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_rd [N];
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (1024),
            .WAIT_CYCLES (g == 0 ? 1 : (g == 1 ? 0 : 15))
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .dmem_req   (req[g]),
            .dmem_addr  (addr[g]),
            .dmem_we    (we[g]),
            .dmem_be    (be[g]),
            .dmem_wdata (wdata[g]),
            .dmem_rdata (rdata[g]),
            .dmem_ready (ready[g]),
            .dmem_err   (err[g]),
            .busy       (busy[g])
        );
    end

    function automatic int wc(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 15);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transaction on instance i; b2b means req was held from the previous one.
    task automatic xact(input int i, input bit w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] rd, input bit e,
                        input bit keep, input bit b2b);
        exp_t x;
        int   cyc, bcnt;
        bit   seen;
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
        if (!w) last_rd[i] = e ? 32'h0 : rd;
        x.inst = i; x.rdata = last_rd[i]; x.err = e;
        sb.push_back(x);
        cyc = 0; bcnt = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (busy[i]) bcnt++;
            seen = ready[i];
        end
        check("latency", cyc, wc(i) + 1 + int'(b2b));
        check("busy_cycles", bcnt, wc(i) + 1);
        if (!keep) begin
            @(negedge clk);
            req[i] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (ready[i]) begin
                if (sb.size() == 0) check("stray_ready", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    check("resp_inst", i, mon_e.inst);
                    check("rdata", rdata[i], mon_e.rdata);
                    check("err", {31'b0, err[i]}, {31'b0, mon_e.err});
                end
            end else if (err[i]) check("err_not_ready", 1, 0);
        end
    end

    initial begin
        req = '0; we = '0; addr = '0; be = '0; wdata = '0;
        foreach (last_rd[k]) last_rd[k] = 32'h0;
        #1 rst_n = 1'b0;
        #10;
        for (int i = 0; i < N; i++) begin
            check("rst_rdata", rdata[i], 32'h0);
            check("rst_flags", {29'b0, ready[i], err[i], busy[i]}, 32'h0);
        end
        #1 rst_n = 1'b1;

        // WAIT_CYCLES=1: full, partial and null writes
        xact(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0);
        xact(0, 0, 32'h10, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0);
        xact(0, 1, 32'h10, 4'h1, 32'h00000055, 0, 0, 0, 0);
        xact(0, 0, 32'h10, 4'h0, 0, 32'hDEADBE55, 0, 0, 0);
        xact(0, 1, 32'h10, 4'h0, 32'h12345678, 0, 0, 0, 0);
        xact(0, 0, 32'h10, 4'hF, 0, 32'hDEADBE55, 0, 0, 0);

        // out of range: word 1024 aliases word 0 in the low index bits
        xact(0, 1, 32'h0, 4'hF, 32'hCAFEF00D, 0, 0, 0, 0);
        xact(0, 0, 32'h1000, 4'hF, 0, 0, 1, 0, 0);
        xact(0, 1, 32'h1000, 4'hF, 32'hFFFFFFFF, 0, 1, 0, 0);
        xact(0, 0, 32'h0, 4'hF, 0, 32'hCAFEF00D, 0, 0, 0);

        // write then immediately-following read of the same word
        xact(0, 1, 32'h14, 4'hF, 32'h600DF00D, 0, 0, 1, 0);
        xact(0, 0, 32'h14, 4'hF, 0, 32'h600DF00D, 0, 0, 1);

        // reset during WAIT discards the write
        xact(0, 1, 32'h20, 4'hF, 32'h11111111, 0, 0, 0, 0);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; be[0] = 4'hF; wdata[0] = 32'h22222222;
        @(posedge clk); #1;
        check("abort_busy_wait", {31'b0, busy[0]}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0; req[0] = 1'b0;
        #1;
        check("abort_busy_rst", {31'b0, busy[0]}, 32'h0);
        check("abort_rdata_rst", rdata[0], 32'h0);
        #1 rst_n = 1'b1;
        foreach (last_rd[k]) last_rd[k] = 32'h0;
        repeat (3) @(posedge clk);
        xact(0, 0, 32'h20, 4'hF, 0, 32'h11111111, 0, 0, 0);

        // WAIT_CYCLES=0: three held reads, ready every 2 cycles
        xact(1, 1, 32'h40, 4'hF, 32'hA0A0A0A0, 0, 0, 0, 0);
        xact(1, 1, 32'h44, 4'hF, 32'hB1B1B1B1, 0, 0, 0, 0);
        xact(1, 1, 32'h48, 4'hF, 32'hC2C2C2C2, 0, 0, 0, 0);
        xact(1, 0, 32'h40, 4'hF, 0, 32'hA0A0A0A0, 0, 1, 0);
        xact(1, 0, 32'h44, 4'hF, 0, 32'hB1B1B1B1, 0, 1, 1);
        xact(1, 0, 32'h48, 4'hF, 0, 32'hC2C2C2C2, 0, 0, 1);

        // WAIT_CYCLES=15: 16 busy cycles, one pulse per request
        xact(2, 1, 32'h8, 4'hF, 32'h0BADF00D, 0, 0, 0, 0);
        xact(2, 0, 32'h8, 4'hF, 0, 32'h0BADF00D, 0, 1, 0);
        xact(2, 0, 32'h8, 4'h0, 0, 32'h0BADF00D, 0, 0, 1);

        repeat (20) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
